keccak_req_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one keccak_core_NOPL between N_REQ hash requesters.

---
 rtl/keccak_req_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_keccak_req_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_req_arbiter.sv
// rtl/keccak_req_arbiter.sv - round-robin sequencer sharing one keccak core among N_REQ requesters (optional watchdog: KECCAK_ARB_TIMEOUT_EN)
module keccak_req_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_i,
  input  logic [3*N_REQ-1:0]  req_cmode_i,
  input  logic [11*N_REQ-1:0] req_d_i,
  input  logic [64*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]    req_last_i,
  output logic [N_REQ-1:0]    req_ack_o,
  output logic [N_REQ-1:0]    grant_o,
  output logic                core_start_o,
  output logic [2:0]          core_cmode_o,
  output logic [10:0]         core_d_o,
  output logic [63:0]         core_dt_o,
  output logic                core_last_o,
  input  logic                core_valid_i,
  input  logic                core_fin_i,
  input  logic [31:0]         core_hash_i,
  output logic [31:0]         hash_o,
  output logic                hash_vld_o,
  output logic [ID_W-1:0]     hash_id_o,
  output logic                done_o,
  output logic                err_o
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_ABSORB, S_SQUEEZE} state_t;

  state_t            r_state, w_state_nxt;
  logic [N_REQ-1:0]  r_grant;
  logic [ID_W-1:0]   r_gid, r_rr_ptr, w_win_id;
  logic              w_found;
  logic [2:0]        r_cmode, w_win_cmode;
  logic [10:0]       r_d, w_win_d;
  logic [11:0]       r_count, w_d_words, w_exp_words;
  logic [31:0]       r_hash;
  logic              r_hash_vld, r_done;
  logic [ID_W-1:0]   r_hash_id;
  logic [63:0]       w_cur_data;
  logic              w_take, w_hash_take, w_job_end, w_timeout;

  function automatic logic [ID_W-1:0] f_wrap(input int v);
    return ID_W'(v % N_REQ);
  endfunction

  // 12-bit arithmetic so d=2047 rounds up to 64 words instead of wrapping
  assign w_d_words   = ({1'b0, r_d} + 12'd31) >> 5;
  assign w_exp_words = (w_d_words == 12'd0) ? 12'd1 : w_d_words;

  // round-robin pick: first set request after the last winner, wrapping
  always_comb begin
    w_found  = 1'b0;
    w_win_id = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!w_found && req_i[f_wrap(int'(r_rr_ptr) + i)]) begin
        w_found  = 1'b1;
        w_win_id = f_wrap(int'(r_rr_ptr) + i);
      end
    end
  end

  // per-requester muxes: winner's job parameters and owner's current word
  always_comb begin
    w_cur_data  = '0;
    w_win_cmode = '0;
    w_win_d     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (r_gid == ID_W'(k)) w_cur_data = req_data_i[k*64 +: 64];
      if (w_win_id == ID_W'(k)) begin
        w_win_cmode = req_cmode_i[k*3 +: 3];
        w_win_d     = req_d_i[k*11 +: 11];
      end
    end
  end

`ifdef KECCAK_ARB_TIMEOUT_EN
  logic [12:0] r_wdog;
  logic        r_err;
  logic        w_busy_idle;

  assign w_busy_idle = (r_state == S_ABSORB || r_state == S_SQUEEZE) && !core_valid_i && !core_fin_i;
  assign w_timeout   = w_busy_idle && (r_wdog == 13'(TIMEOUT_CYC - 1));
  assign err_o       = r_err;

  // watchdog: counts stalled cycles while the core owns a job
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wdog <= (w_busy_idle && !w_timeout) ? r_wdog + 13'd1 : 13'd0;
      r_err  <= w_timeout;
    end
  end
`else
  // no watchdog: a stalled core holds the grant indefinitely (expression is constant 0)
  assign w_timeout = (TIMEOUT_CYC < 0);
  assign err_o     = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next state and core-side combinational outputs
  always_comb begin
    w_state_nxt  = r_state;
    core_start_o = 1'b0;
    req_ack_o    = '0;
    core_dt_o    = '0;
    core_last_o  = 1'b0;
    w_take       = 1'b0;
    w_hash_take  = 1'b0;
    w_job_end    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_take      = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        core_start_o = 1'b1;
        w_state_nxt  = S_ABSORB;
      end
      S_ABSORB: begin
        core_dt_o   = w_cur_data;
        core_last_o = req_last_i[r_gid];
        if (core_valid_i) begin
          req_ack_o = r_grant;
          if (req_last_i[r_gid]) w_state_nxt = S_SQUEEZE;
        end
        if (w_timeout) begin
          w_job_end   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_SQUEEZE: begin
        if (core_fin_i) begin
          w_hash_take = 1'b1;
          if (r_count + 12'd1 >= w_exp_words) begin
            w_job_end   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        if (w_timeout) begin
          w_job_end   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // job bookkeeping: grant/latched parameters, digest register, word count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant    <= '0;
      r_gid      <= '0;
      r_rr_ptr   <= ID_W'(N_REQ - 1);
      r_cmode    <= '0;
      r_d        <= '0;
      r_count    <= '0;
      r_hash     <= '0;
      r_hash_vld <= 1'b0;
      r_hash_id  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_hash_vld <= 1'b0;
      r_done     <= 1'b0;
      if (w_take) begin
        r_grant  <= N_REQ'(1) << w_win_id;
        r_gid    <= w_win_id;
        r_rr_ptr <= w_win_id;
        r_cmode  <= w_win_cmode;
        r_d      <= w_win_d;
        r_count  <= '0;
      end
      if (w_hash_take) begin
        r_hash     <= core_hash_i;
        r_hash_vld <= 1'b1;
        r_hash_id  <= r_gid;
        r_count    <= r_count + 12'd1;
      end
      if (w_job_end) begin
        r_grant <= '0;
        r_done  <= 1'b1;
        r_count <= '0;
      end
    end
  end

  assign grant_o      = r_grant;
  assign core_cmode_o = r_cmode;
  assign core_d_o     = r_d;
  assign hash_o       = r_hash;
  assign hash_vld_o   = r_hash_vld;
  assign hash_id_o    = r_hash_id;
  assign done_o       = r_done;

endmodule

// File: tb/tb_keccak_req_arbiter.sv
// tb/tb_keccak_req_arbiter.sv - self-checking bench for keccak_req_arbiter
module tb_keccak_req_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_i, req_last_i, req_ack_o, grant_o;
  logic [3*N-1:0] req_cmode_i;
  logic [11*N-1:0] req_d_i;
  logic [64*N-1:0] req_data_i;
  logic           core_start_o, core_last_o, core_valid_i, core_fin_i;
  logic [2:0]     core_cmode_o;
  logic [10:0]    core_d_o;
  logic [63:0]    core_dt_o;
  logic [31:0]    core_hash_i, hash_o;
  logic           hash_vld_o, done_o, err_o;
  logic [IDW-1:0] hash_id_o;

  keccak_req_arbiter #(.N_REQ(N), .ID_W(IDW), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .req_cmode_i(req_cmode_i), .req_d_i(req_d_i),
    .req_data_i(req_data_i), .req_last_i(req_last_i), .req_ack_o(req_ack_o), .grant_o(grant_o),
    .core_start_o(core_start_o), .core_cmode_o(core_cmode_o), .core_d_o(core_d_o),
    .core_dt_o(core_dt_o), .core_last_o(core_last_o), .core_valid_i(core_valid_i),
    .core_fin_i(core_fin_i), .core_hash_i(core_hash_i), .hash_o(hash_o), .hash_vld_o(hash_vld_o),
    .hash_id_o(hash_id_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] hash; int id; bit done; } exp_t;
  typedef struct {
    bit do_rst; logic [3:0] set_m; logic [3:0] clr_m; int id; logic [2:0] cmode;
    logic [10:0] d; int nw; int ew; int lat; bit stray; bit drop;
  } row_t;

  exp_t sb[$];
  row_t tab[$];
  int   n_run = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one clock; registered digest outputs are checked against the scoreboard
  task automatic tick();
    @(posedge clk);
    #1;
    if (hash_vld_o) begin
      if (sb.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL sb_unexpected: hash %0h id %0d appeared, nothing expected", hash_o, hash_id_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_hash", hash_o, e.hash);
        chk("sb_id", hash_id_o, e.id);
        chk("sb_done", done_o, e.done);
      end
    end else if (done_o && !err_o) begin
      n_run++;
      n_fail++;
      $display("FAIL done_without_vld: got done_o=1 expected 0");
    end
  endtask

  task automatic run_job(input int id, input logic [2:0] cm, input logic [10:0] d, input int nw,
                         input int ew, input int lat, input bit stray, input bit drop,
                         input logic [31:0] seed);
    int n;
    logic [3:0] one;
    one = 4'(1 << id);
    n = 0;
    req_cmode_i[id*3 +: 3] = cm;
    req_d_i[id*11 +: 11]   = d;
    while (grant_o == 0 && n < 20) begin
      tick();
      n++;
    end
    chk("grant", grant_o, one);
    if (lat > 0) chk("grant_lat", n, lat);
    if (grant_o != one) return;
    chk("start", core_start_o, 1);
    chk("cmode", core_cmode_o, cm);
    chk("d", core_d_o, d);
    if (drop) req_i[id] = 1'b0;
    tick();
    chk("start_once", core_start_o, 0);
    if (stray) begin
      core_fin_i  = 1'b1;
      core_hash_i = 32'hdead_beef;
      tick();
      core_fin_i  = 1'b0;
    end
    for (int w = 0; w < nw; w++) begin
      req_data_i[id*64 +: 64] = {seed, 32'(w)};
      req_last_i[id] = (w == nw - 1);
      core_valid_i = 1'b1;
      #1;
      chk("dt", core_dt_o, {seed, 32'(w)});
      chk("ack", req_ack_o, one);
      chk("last", core_last_o, (w == nw - 1));
      tick();
      core_valid_i   = 1'b0;
      req_last_i[id] = 1'b0;
    end
    for (int i = 0; i < ew; i++) begin
      if (i % 3 == 2) tick();
      core_fin_i  = 1'b1;
      core_hash_i = seed ^ 32'(i);
      sb.push_back('{seed ^ 32'(i), id, (i == ew - 1)});
      tick();
      core_fin_i = 1'b0;
    end
    chk("grant_released", grant_o, 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_i = '0; req_last_i = '0; req_cmode_i = '0; req_d_i = '0; req_data_i = '0;
    core_valid_i = 1'b0; core_fin_i = 1'b0; core_hash_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {grant_o, req_ack_o, core_start_o, core_cmode_o, core_d_o, core_last_o,
                       hash_vld_o, hash_id_o, done_o, err_o}, 0);
    chk("reset_dt", core_dt_o, 0);
    chk("reset_hash", hash_o, 0);
    rst = 1'b0;

    // idle: nothing forwarded even with busy-looking inputs; stray fin ignored
    req_data_i = {N{64'haaaa_5555_aaaa_5555}};
    req_last_i = '1;
    core_valid_i = 1'b1;
    core_fin_i = 1'b1;
    tick();
    chk("idle_ack_last_grant", {req_ack_o, core_last_o, grant_o}, 0);
    chk("idle_dt", core_dt_o, 0);
    req_last_i = '0;
    core_valid_i = 1'b0;
    core_fin_i = 1'b0;

    //                 rst   set      clr      id cm    d         nw ew  lat stray drop
    tab.push_back('{1'b0, 4'b0001, 4'b0001, 0, 3'd1, 11'd256,  2, 8,  1, 1'b0, 1'b0});
    tab.push_back('{1'b0, 4'b0110, 4'b0010, 1, 3'd2, 11'd64,   1, 2,  1, 1'b0, 1'b0});
    tab.push_back('{1'b0, 4'b0000, 4'b0100, 2, 3'd3, 11'd96,   3, 3,  1, 1'b0, 1'b0});
    tab.push_back('{1'b1, 4'b1111, 4'b0000, 0, 3'd4, 11'd32,   1, 1,  1, 1'b0, 1'b0});
    tab.push_back('{1'b0, 4'b0000, 4'b0000, 1, 3'd5, 11'd33,   1, 2,  1, 1'b0, 1'b0});
    tab.push_back('{1'b0, 4'b0000, 4'b0000, 2, 3'd6, 11'd0,    2, 1,  1, 1'b0, 1'b0});
    tab.push_back('{1'b0, 4'b0000, 4'b0000, 3, 3'd7, 11'd160,  1, 5,  1, 1'b0, 1'b0});
    tab.push_back('{1'b0, 4'b0000, 4'b1100, 0, 3'd1, 11'd128,  1, 4,  1, 1'b0, 1'b0});
    tab.push_back('{1'b0, 4'b0000, 4'b0010, 1, 3'd2, 11'd64,   1, 2,  1, 1'b0, 1'b0});
    tab.push_back('{1'b0, 4'b0000, 4'b0001, 0, 3'd3, 11'd32,   1, 1,  1, 1'b0, 1'b0});
    tab.push_back('{1'b0, 4'b1000, 4'b1000, 3, 3'd4, 11'd100,  2, 4,  1, 1'b1, 1'b0});
    tab.push_back('{1'b0, 4'b0100, 4'b0100, 2, 3'd5, 11'd224,  2, 7,  1, 1'b0, 1'b1});
    tab.push_back('{1'b0, 4'b0010, 4'b0010, 1, 3'd6, 11'd2047, 1, 64, 1, 1'b0, 1'b0});

    foreach (tab[r]) begin
      if (tab[r].do_rst) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      req_i = req_i | tab[r].set_m;
      run_job(tab[r].id, tab[r].cmode, tab[r].d, tab[r].nw, tab[r].ew, tab[r].lat,
              tab[r].stray, tab[r].drop, 32'hc0de_0000 + 32'(r << 8));
      req_i = req_i & ~tab[r].clr_m;
    end

    // reset in the middle of SQUEEZE, then a fresh request
    req_i = 4'b0001;
    req_d_i[10:0] = 11'd256;
    tick();
    chk("mid_grant", grant_o, 4'b0001);
    tick();
    req_data_i[63:0] = 64'h1234;
    req_last_i[0] = 1'b1;
    core_valid_i = 1'b1;
    tick();
    core_valid_i = 1'b0;
    req_last_i[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      core_fin_i = 1'b1;
      core_hash_i = 32'h5a00 + 32'(i);
      sb.push_back('{32'h5a00 + 32'(i), 0, 1'b0});
      tick();
    end
    core_fin_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_outs", {grant_o, req_ack_o, core_start_o, core_cmode_o, core_d_o, core_last_o,
                         hash_vld_o, hash_id_o, done_o, err_o}, 0);
    chk("rst_mid_hash", hash_o, 0);
    req_i = 4'b0100;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_job(2, 3'd2, 11'd64, 1, 2, 1, 1'b0, 1'b0, 32'h7777_0000);
    req_i = '0;

`ifdef KECCAK_ARB_TIMEOUT_EN
    begin
      int n;
      req_i = 4'b0001;
      tick();
      chk("to_grant", grant_o, 4'b0001);
      tick();
      n = 0;
      while (!err_o && n < 200) begin
        tick();
        n++;
      end
      chk("to_latency", n, 64);
      chk("to_done", done_o, 1);
      chk("to_grant_clear", grant_o, 0);
      req_i = '0;
      tick();
      chk("to_idle", {err_o, done_o, core_start_o, grant_o}, 0);
    end
`endif

    repeat (3) tick();
    chk("final_sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
